// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory with sub-word loads/stores and a sequential clear engine.
// Optional macro DM_TRACE_EN prints every committed store.
module dm_bytelane #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] MemAddr,
    input  logic [31:0] Memdata,
    input  logic        MemWrite,
    input  logic [2:0]  MemOp,
    output logic [31:0] Memout,
    output logic        AddrErr,
    output logic        Busy
);
    localparam int DEPTH = 1 << ADDR_BITS;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [31:0]          ram [DEPTH];
    logic [31:0]          off, rd, rep, merged, wdata;
    logic [15:0]          h16;
    logic [7:0]           b8;
    logic [ADDR_BITS-1:0] ridx, widx;
    logic [3:0]           be;
    logic [1:0]           sz;
    logic                 st, we;

    assign Busy = state_q == CLEAR;

    always_comb begin
        sz = MemOp[1:0];
        off = MemAddr - BASE_ADDR;
        ridx = off[ADDR_BITS+1:2];
        AddrErr = sz == 2'b11 || (sz == 2'b00 && MemAddr[1:0] != 2'b00) ||
                  (sz == 2'b01 && MemAddr[0]) || |(off >> (ADDR_BITS + 2));
        rd = ram[ridx];
        // Replicate store data across lanes so the byte enables alone pick the target lanes.
        rep = sz == 2'b00 ? Memdata : sz == 2'b01 ? {2{Memdata[15:0]}} : {4{Memdata[7:0]}};
        be = sz == 2'b00 ? 4'hf : sz == 2'b01 ? (MemAddr[1] ? 4'hc : 4'h3) : 4'b0001 << MemAddr[1:0];
        merged = rd;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
        st = MemWrite && state_q == IDLE && !reset && !AddrErr;
        we = !reset && (state_q == CLEAR || st);
        widx = state_q == CLEAR ? idx_q : ridx;
        wdata = state_q == CLEAR ? 32'h0 : merged;
        h16 = MemAddr[1] ? rd[31:16] : rd[15:0];
        b8 = MemAddr[0] ? h16[15:8] : h16[7:0];
        Memout = (Busy || AddrErr) ? 32'h0 :
                 sz == 2'b00 ? rd :
                 sz == 2'b01 ? {{16{~MemOp[2] & h16[15]}}, h16} :
                               {{24{~MemOp[2] & b8[7]}}, b8};
        state_d = (state_q == CLEAR && &idx_q) ? IDLE : state_q;
        idx_d = state_q == CLEAR ? idx_q + 1'b1 : idx_q;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
        end
        if (we) ram[widx] <= wdata;
`ifdef DM_TRACE_EN
        if (st) $display("*%h <= %h", MemAddr, merged);
`endif
    end
endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed and randomized checks of dm_bytelane against a byte-array reference model.
module tb_dm_bytelane;
    logic        Clk = 1'b0;
    logic        reset = 1'b0, MemWrite = 1'b0;
    logic [31:0] MemAddr = '0, Memdata = '0;
    logic [2:0]  MemOp = '0;
    logic [31:0] Memout;
    logic        AddrErr, Busy;

    dm_bytelane #(.ADDR_BITS(4), .BASE_ADDR(32'h0)) dut (
        .Clk(Clk), .reset(reset), .MemAddr(MemAddr), .Memdata(Memdata),
        .MemWrite(MemWrite), .MemOp(MemOp), .Memout(Memout),
        .AddrErr(AddrErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_err = 0, n_chk = 0;
    logic [7:0] m [64];
    bit known = 0, m_busy = 0;
    int clr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] op);
        return op[1:0] == 2'b11 || (op[1:0] == 2'b00 && a[1:0] != 2'b00) ||
               (op[1:0] == 2'b01 && a[0]) || a >= 32'd64;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
        logic [15:0] h;
        logic [7:0] b;
        if (m_busy || m_err(a, op)) return 32'h0;
        if (op[1:0] == 2'b00) return {m[a+3], m[a+2], m[a+1], m[a]};
        if (op[1:0] == 2'b01) begin
            h = {m[a+1], m[a]};
            return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
        end
        b = m[a];
        return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    // One clock: drive, check before the edge, advance the model on the edge.
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] op, input bit dir, input logic [31:0] xo, input bit xe);
        reset = r; MemWrite = w; MemAddr = a; Memdata = d; MemOp = op;
        #4;
        if (known) begin
            chk("addr_err", AddrErr, m_err(a, op));
            chk("memout", Memout, m_load(a, op));
            chk("busy", Busy, m_busy);
        end
        if (dir) begin
            chk("dir_out", Memout, xo);
            chk("dir_err", AddrErr, xe);
        end
        @(posedge Clk);
        if (r) begin
            known = 1; m_busy = 1; clr = 0;
        end else if (m_busy) begin
            for (int b = 0; b < 4; b++) m[4*clr+b] = 8'h0;
            clr++;
            if (clr == 16) m_busy = 0;
        end else if (w && !m_err(a, op)) begin
            if (op[1:0] == 2'b00) for (int b = 0; b < 4; b++) m[a+b] = d[8*b +: 8];
            else if (op[1:0] == 2'b01) begin m[a] = d[7:0]; m[a+1] = d[15:8]; end
            else m[a] = d[7:0];
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        step(r, w, a, d, op, 0, 32'h0, 0);
    endtask

    task automatic probe(input logic [31:0] a, input logic [2:0] op, input logic [31:0] xo, input bit xe);
        step(0, 0, a, 32'h0, op, 1, xo, xe);
    endtask

    task automatic busy_len();
        int cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            cyc(0, cnt == 0, 32'h8, 32'hDEAD_BEEF, 3'b000);
            cnt++;
        end
        chk("busy_len", cnt, 16);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk("busy_after_reset", Busy, 1);
        busy_len();
        for (int i = 0; i < 16; i++) probe(4 * i, 3'b000, 32'h0, 0);

        cyc(0, 1, 32'h8, 32'h1122_3344, 3'b000);
        cyc(0, 1, 32'h9, 32'h0000_00AA, 3'b010);
        cyc(0, 1, 32'hA, 32'h0000_BEEF, 3'b001);
        probe(32'h8, 3'b000, 32'hBEEF_AA44, 0);
        probe(32'h9, 3'b010, 32'hFFFF_FFAA, 0);
        probe(32'h9, 3'b110, 32'h0000_00AA, 0);
        probe(32'hA, 3'b001, 32'hFFFF_BEEF, 0);
        probe(32'hA, 3'b101, 32'h0000_BEEF, 0);
        probe(32'h8, 3'b010, 32'h0000_0044, 0);

        step(0, 1, 32'h6, 32'hCAFE_F00D, 3'b000, 1, 32'h0, 1);
        probe(32'h4, 3'b000, 32'h0, 0);
        step(0, 1, 32'h5, 32'h0000_1234, 3'b001, 1, 32'h0, 1);
        probe(32'h4, 3'b000, 32'h0, 0);
        probe(32'h8, 3'b011, 32'h0, 1);
        probe(32'h40, 3'b000, 32'h0, 1);
        probe(32'h3C, 3'b000, 32'h0, 0);

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 32'h8, 0, 3'b000);
        cyc(1, 0, 0, 0, 0);
        busy_len();
        step(0, 1, 32'h4, 32'h5, 3'b000, 1, 32'h0, 0);
        probe(32'h4, 3'b000, 32'h5, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom % 8 == 0) ? $urandom : $urandom % 72;
            cyc($urandom % 100 == 0, $urandom % 2 == 1, a, $urandom, 3'($urandom % 8));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Parametrised data memory for the single-cycle/multi-cycle MIPS datapath.
- Supports word, halfword and byte stores with byte-lane merging.
- Supports sign- and zero-extended sub-word loads.
- Flags alignment and range errors.
- Replaces the one-cycle bulk clear on reset with a sequential clear engine that sweeps one word per cycle and reports Busy.

Parameters:
- ADDR_BITS, 10, word-index width; DEPTH = 2**ADDR_BITS words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- Clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemAddr  in  32  byte address.
- Memdata  in  32  store data; sub-word stores take bits [7:0] or [15:0].
- MemWrite  in  1  store strobe.
- MemOp  in  3  [1:0] size: 00 word, 01 half, 10 byte, 11 reserved. [2] = 1 zero-extends loads, 0 sign-extends.
- Memout  out  32  combinational load data, already extended.
- AddrErr  out  1  combinational: access is misaligned, out of range, or uses a reserved size.
- Busy  out  1  registered: the clear engine is running.

Behaviour:
- Storage is ram[0..DEPTH-1] of 32 bits. The word index is (MemAddr-BASE_ADDR)[ADDR_BITS+1:2]. The byte lane is MemAddr[1:0].

Error detection (combinational; AddrErr reset value follows its inputs):
- AddrErr = 1 if any of the following hold:
  - size=word and MemAddr[1:0]!=0;
  - size=half and MemAddr[0]!=0;
  - size=11;
  - unsigned (MemAddr-BASE_ADDR) >= 4*DEPTH.

Clear engine FSM:
- States are IDLE and CLEAR, with a registered index idx of ADDR_BITS bits.
- Any edge with reset=1 sets state=CLEAR and idx=0. This applies from any state, including mid-CLEAR (the sweep restarts at 0).
- Each edge in CLEAR with reset=0 writes ram[idx]<=0 and increments idx.
- The edge that clears idx=DEPTH-1 moves the FSM to IDLE.
- Busy = (state==CLEAR). Busy is 1 after any reset edge and falls exactly DEPTH edges after reset deasserts.
- Power-up state is undefined until the first reset.

Stores (commit on posedge):
- A store commits only when MemWrite=1, state==IDLE, reset=0 and AddrErr=0. Otherwise it is silently dropped with no partial write.
- Word: whole word replaced.
- Half: lanes {1,0} when MemAddr[1]=0, else lanes {3,2}, loaded with Memdata[15:0]; other lanes unchanged.
- Byte: lane MemAddr[1:0] loaded with Memdata[7:0]; other lanes unchanged.

Loads (combinational, zero latency):
- Word: ram word unchanged.
- Half: selected 16 bits, extended per MemOp[2].
- Byte: selected 8 bits, extended per MemOp[2].
- Memout = 0 while Busy=1 or AddrErr=1.
- A load and a store to the same word in the same cycle: Memout shows the old contents until the edge (read-before-write).

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every committed store, print "*%h <= %h" with the byte address and the merged 32-bit word written. Nothing is printed for dropped stores or for clear-engine writes.
- Undefined: no simulation output; RTL is identical otherwise.

Test Plan (all scenarios use ADDR_BITS=4, i.e. DEPTH=16, and BASE_ADDR=0):
1. Clear timing:
   - Stimulus: hold reset 3 cycles, then release.
   - Required: Busy=1 for exactly 16 edges after release, then 0. All 16 words read 0. A store attempted while Busy is dropped; that word reads 0 afterwards.
2. Store merging:
   - Stimulus: sw 0x11223344 @0x8; sb 0xAA @0x9; sh 0xBEEF @0xA.
   - Required: lw @0x8 returns 0xBEEFAA44.
3. Load extension, with word @0x8 = 0xBEEFAA44:
   - lb @0x9 -> 0xFFFFFFAA.
   - lbu @0x9 -> 0x000000AA.
   - lh @0xA -> 0xFFFFBEEF.
   - lhu @0xA -> 0x0000BEEF.
   - lb @0x8 -> 0x00000044.
4. Errors:
   - sw @0x6 -> AddrErr=1, memory unchanged.
   - sh @0x5 -> AddrErr=1.
   - MemOp size=11 -> AddrErr=1.
   - lw @0x40 -> AddrErr=1, Memout=0.
   - lw @0x3C -> AddrErr=0.
5. Reset mid-clear and read-before-write:
   - Stimulus: reset at sweep index 7, released next cycle.
   - Required: Busy stays high a further 16 edges after release.
   - Stimulus: in IDLE, lw and sw 0x5 to @0x4 in the same cycle, where the word holds 0.
   - Required: Memout=0 before the edge, 0x5 after.
6. With DM_TRACE_EN:
   - Stimulus: sb 0xAA @0x9 over word 0x11223344.
   - Required: prints "*00000009 <= 1122aa44". A dropped store prints nothing.
